// File: rtl/bus_xbar_pipelined.sv
// Pipelined NrHosts x NrDevices system bus: round-robin arbitration, base/mask decode,
// in-order response tag FIFO and an internal error slave for unmapped addresses.
module bus_xbar_pipelined #(
    parameter int NrHosts        = 2,
    parameter int NrDevices      = 8,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NrHosts-1:0]                    host_req_i,
    output logic [NrHosts-1:0]                    host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]       host_addr_i,
    input  logic [NrHosts-1:0]                    host_we_i,
    input  logic [NrHosts*(DataWidth/8)-1:0]      host_be_i,
    input  logic [NrHosts*DataWidth-1:0]          host_wdata_i,
    output logic [NrHosts-1:0]                    host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]          host_rdata_o,
    output logic [NrHosts-1:0]                    host_err_o,
    output logic [NrDevices-1:0]                  device_req_o,
    output logic [NrDevices*AddressWidth-1:0]     device_addr_o,
    output logic [NrDevices-1:0]                  device_we_o,
    output logic [NrDevices*(DataWidth/8)-1:0]    device_be_o,
    output logic [NrDevices*DataWidth-1:0]        device_wdata_o,
    input  logic [NrDevices-1:0]                  device_rvalid_i,
    input  logic [NrDevices*DataWidth-1:0]        device_rdata_i,
    input  logic [NrDevices-1:0]                  device_err_i,
    input  logic [NrDevices*AddressWidth-1:0]     cfg_device_addr_base,
    input  logic [NrDevices*AddressWidth-1:0]     cfg_device_addr_mask
);
    localparam int BeWidth = DataWidth / 8;
    localparam int HostW   = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int TgtW    = $clog2(NrDevices + 1);
    localparam int PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW    = $clog2(MaxOutstanding + 1);
    localparam logic [TgtW-1:0] TgtErr  = TgtW'(NrDevices);
    localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    logic [HostW-1:0] r_rr_ptr;
    logic [HostW-1:0] r_fifo_host [MaxOutstanding];
    logic [TgtW-1:0]  r_fifo_tgt  [MaxOutstanding];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic [TgtW-1:0]  r_last_tgt;

    logic                    w_sel_valid;
    logic                    w_hit;
    logic [HostW-1:0]        w_sel_host;
    logic [AddressWidth-1:0] w_sel_addr;
    logic                    w_sel_we;
    logic [BeWidth-1:0]      w_sel_be;
    logic [DataWidth-1:0]    w_sel_wdata;
    logic [TgtW-1:0]         w_tgt;
    logic                    w_empty;
    logic                    w_full;
    logic [HostW-1:0]        w_head_host;
    logic [TgtW-1:0]         w_head_tgt;
    logic                    w_head_is_err;
    logic                    w_dev_rvalid;
    logic [DataWidth-1:0]    w_dev_rdata;
    logic                    w_dev_err;
    logic [DataWidth-1:0]    w_rsp_rdata;
    logic                    w_rsp_err;
    logic                    w_pop;
    logic                    w_grant;
    logic [NrDevices-1:0]    w_rvalid_ok;

    // Round-robin pick: first requester at or after r_rr_ptr, wrapping.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_host  = '0;
        w_hit       = 1'b0;
        for (int i = 0; i < NrHosts; i++) begin
            for (int h = 0; h < NrHosts; h++) begin
                w_hit       = !w_sel_valid && host_req_i[h] && (((int'(r_rr_ptr) + i) % NrHosts) == h);
                w_sel_host  = w_hit ? HostW'(h) : w_sel_host;
                w_sel_valid = w_sel_valid | w_hit;
            end
        end
    end

    // Winner request fields and address decode (lowest matching device wins).
    always_comb begin
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_be    = '0;
        w_sel_wdata = '0;
        for (int h = 0; h < NrHosts; h++) begin
            w_sel_addr  = (w_sel_host == HostW'(h)) ? host_addr_i[h*AddressWidth +: AddressWidth] : w_sel_addr;
            w_sel_we    = (w_sel_host == HostW'(h)) ? host_we_i[h] : w_sel_we;
            w_sel_be    = (w_sel_host == HostW'(h)) ? host_be_i[h*BeWidth +: BeWidth] : w_sel_be;
            w_sel_wdata = (w_sel_host == HostW'(h)) ? host_wdata_i[h*DataWidth +: DataWidth] : w_sel_wdata;
        end
        w_tgt = TgtErr;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            w_tgt = ((w_sel_addr & cfg_device_addr_mask[d*AddressWidth +: AddressWidth]) ==
                     cfg_device_addr_base[d*AddressWidth +: AddressWidth]) ? TgtW'(d) : w_tgt;
        end
    end

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == CntFull);
    assign w_head_host   = r_fifo_host[r_rd_ptr];
    assign w_head_tgt    = r_fifo_tgt[r_rd_ptr];
    assign w_head_is_err = (w_head_tgt == TgtErr);

    // Response from the device at the FIFO head; other devices' rvalid is ignored.
    always_comb begin
        w_dev_rvalid = 1'b0;
        w_dev_rdata  = '0;
        w_dev_err    = 1'b0;
        for (int d = 0; d < NrDevices; d++) begin
            w_rvalid_ok[d] = !w_empty && (w_head_tgt == TgtW'(d));
            w_dev_rvalid   = w_rvalid_ok[d] ? device_rvalid_i[d] : w_dev_rvalid;
            w_dev_rdata    = w_rvalid_ok[d] ? device_rdata_i[d*DataWidth +: DataWidth] : w_dev_rdata;
            w_dev_err      = w_rvalid_ok[d] ? device_err_i[d] : w_dev_err;
        end
    end

    // Error-slave entries pop the cycle after their grant, since they reach the head immediately.
    assign w_pop       = !w_empty && (w_head_is_err || w_dev_rvalid);
    assign w_grant     = w_sel_valid && (!w_full || w_pop) && (w_empty || (w_tgt == r_last_tgt));
    assign w_rsp_rdata = w_head_is_err ? {DataWidth{1'b0}} : w_dev_rdata;
    assign w_rsp_err   = w_head_is_err | w_dev_err;

    // Grant, request forwarding and response routing outputs.
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_rdata_o  = '0;
        host_err_o    = '0;
        device_req_o  = '0;
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h]    = w_grant && (w_sel_host == HostW'(h));
            host_rvalid_o[h] = w_pop && (w_head_host == HostW'(h));
            host_rdata_o[h*DataWidth +: DataWidth] = host_rvalid_o[h] ? w_rsp_rdata : {DataWidth{1'b0}};
            host_err_o[h]    = host_rvalid_o[h] & w_rsp_err;
        end
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d] = w_grant && (w_tgt == TgtW'(d));
        end
    end

    assign device_addr_o  = {NrDevices{w_sel_addr}};
    assign device_we_o    = {NrDevices{w_sel_we}};
    assign device_be_o    = {NrDevices{w_sel_be}};
    assign device_wdata_o = {NrDevices{w_sel_wdata}};

    // Arbitration pointer and response tag FIFO state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last_tgt <= '0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                r_fifo_host[i] <= '0;
                r_fifo_tgt[i]  <= '0;
            end
        end else begin
            if (w_grant) begin
                r_rr_ptr              <= (w_sel_host == HostW'(NrHosts - 1)) ? '0 : w_sel_host + 1'b1;
                r_fifo_host[r_wr_ptr] <= w_sel_host;
                r_fifo_tgt[r_wr_ptr]  <= w_tgt;
                r_wr_ptr              <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + 1'b1;
                r_last_tgt            <= w_tgt;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    bus_xbar_pipelined_chk #(
        .NrHosts        (NrHosts),
        .NrDevices      (NrDevices),
        .CntW           (CntW),
        .MaxOutstanding (MaxOutstanding)
    ) u_chk (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .push_i          (w_grant),
        .pop_i           (w_pop),
        .count_i         (r_count),
        .host_gnt_i      (host_gnt_o),
        .device_req_i    (device_req_o),
        .device_rvalid_i (device_rvalid_i),
        .rvalid_ok_i     (w_rvalid_ok)
    );
endmodule

// Protocol checks for the crossbar: FIFO bounds, one-hot grant/request, stray responses.
module bus_xbar_pipelined_chk #(
    parameter int NrHosts        = 2,
    parameter int NrDevices      = 8,
    parameter int CntW           = 3,
    parameter int MaxOutstanding = 4
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic                 push_i,
    input logic                 pop_i,
    input logic [CntW-1:0]      count_i,
    input logic [NrHosts-1:0]   host_gnt_i,
    input logic [NrDevices-1:0] device_req_i,
    input logic [NrDevices-1:0] device_rvalid_i,
    input logic [NrDevices-1:0] rvalid_ok_i
);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && (count_i == CntW'(MaxOutstanding))));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && (count_i == '0)));
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(host_gnt_i));
    a_req_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(device_req_i));
    // Stray device responses are dropped by the bus; flag them without stopping the run.
    a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((device_rvalid_i & ~rvalid_ok_i) == '0))
        else $warning("device rvalid without a matching outstanding request");
endmodule

// File: tb/tb_bus_xbar_pipelined.sv
// Directed bench for bus_xbar_pipelined: a latency-programmable device model answers
// forwarded requests; every host-side output is compared with hand-computed values.
module tb_bus_xbar_pipelined;
    localparam int NH = 2;
    localparam int ND = 8;
    localparam int DW = 32;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [NH-1:0]     host_req_i;
    logic [NH-1:0]     host_gnt_o;
    logic [NH*AW-1:0]  host_addr_i;
    logic [NH-1:0]     host_we_i;
    logic [NH*4-1:0]   host_be_i;
    logic [NH*DW-1:0]  host_wdata_i;
    logic [NH-1:0]     host_rvalid_o;
    logic [NH*DW-1:0]  host_rdata_o;
    logic [NH-1:0]     host_err_o;
    logic [ND-1:0]     device_req_o;
    logic [ND*AW-1:0]  device_addr_o;
    logic [ND-1:0]     device_we_o;
    logic [ND*4-1:0]   device_be_o;
    logic [ND*DW-1:0]  device_wdata_o;
    logic [ND-1:0]     device_rvalid_i = '0;
    logic [ND*DW-1:0]  device_rdata_i  = '0;
    logic [ND-1:0]     device_err_i    = '0;
    logic [ND*AW-1:0]  cfg_base;
    logic [ND*AW-1:0]  cfg_mask;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned edges    = 0;
    int unsigned lat   [ND];
    int unsigned due_q [ND][$];
    logic [31:0] dat_q [ND][$];

    always #5 clk = ~clk;

    bus_xbar_pipelined #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
        .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
        .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
        .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i), .device_err_i(device_err_i),
        .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Device model: RAM (0) always returns DEADBEEF, others return (d<<28) | addr[15:0].
    always @(posedge clk) begin
        edges <= edges + 1;
        for (int d = 0; d < ND; d++) begin
            if (device_req_o[d]) begin
                due_q[d].push_back(edges + lat[d]);
                dat_q[d].push_back((d == 0) ? 32'hDEADBEEF :
                                   ((32'h1000_0000 * d) | {16'h0000, device_addr_o[d*AW +: 16]}));
            end
        end
    end

    // Present each queued response in the cycle it falls due.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (due_q[d].size() != 0 && due_q[d][0] == edges) begin
                device_rvalid_i[d]         <= 1'b1;
                device_rdata_i[d*DW +: DW] <= dat_q[d][0];
                void'(due_q[d].pop_front());
                void'(dat_q[d].pop_front());
            end else begin
                device_rvalid_i[d] <= 1'b0;
            end
        end
    end

    task automatic drive(input int h, input logic [31:0] a);
        host_req_i[h]            = 1'b1;
        host_addr_i[h*AW +: AW]  = a;
        host_we_i[h]             = 1'b0;
        host_be_i[h*4 +: 4]      = 4'hF;
        host_wdata_i[h*DW +: DW] = 32'h0000_0000;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_gnt"}, {30'h0, host_gnt_o}, 32'h0);
        check_eq({tag, "_rvalid"}, {30'h0, host_rvalid_o}, 32'h0);
        check_eq({tag, "_dreq"}, {24'h0, device_req_o}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni     = 1'b0;
        host_req_i = '0;
        #1;
        check_quiet("rst");
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        exp_g;
        logic        exp_rv;
        logic [31:0] exp_d;
        int          ng;
        int          prev;
        for (int d = 0; d < ND; d++) begin
            lat[d] = 1;
            cfg_base[d*AW +: AW] = 32'h0010_0000 * (d + 1);
            cfg_mask[d*AW +: AW] = 32'hFFFF_0000;
        end
        lat[2]       = 10;
        rst_ni       = 1'b0;
        host_req_i   = '0;
        host_addr_i  = '0;
        host_we_i    = '0;
        host_be_i    = '0;
        host_wdata_i = '0;
        #1;
        check_quiet("por");
        check_eq("por_rdata0", host_rdata_o[31:0], 32'h0);
        check_eq("por_err", {30'h0, host_err_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // Single RAM read, one-cycle device.
        @(negedge clk);
        drive(0, 32'h0010_0010);
        #1;
        check_eq("t1_gnt", {30'h0, host_gnt_o}, 32'h1);
        check_eq("t1_dreq", {24'h0, device_req_o}, 32'h01);
        check_eq("t1_daddr", device_addr_o[31:0], 32'h0010_0010);
        @(negedge clk);
        host_req_i = '0;
        #1;
        check_eq("t1_rvalid", {30'h0, host_rvalid_o}, 32'h1);
        check_eq("t1_rdata", host_rdata_o[31:0], 32'hDEADBEEF);
        check_eq("t1_err", {30'h0, host_err_o}, 32'h0);

        // Both hosts hammer GPIO: grants alternate, responses follow one cycle later.
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k < 6) begin
                drive(0, 32'h0020_0004);
                drive(1, 32'h0020_0008);
            end else begin
                host_req_i = '0;
            end
            #1;
            check_eq("t2_gnt", {30'h0, host_gnt_o}, (k >= 6) ? 32'h0 : ((k % 2 == 0) ? 32'h1 : 32'h2));
            if (k >= 1) begin
                prev = (k - 1) % 2;
                check_eq("t2_rvalid", {30'h0, host_rvalid_o}, (prev == 0) ? 32'h1 : 32'h2);
                check_eq("t2_rdata", host_rdata_o[prev*DW +: DW], (prev == 0) ? 32'h1000_0004 : 32'h1000_0008);
            end
        end

        // UART with latency 10: four grants fill the FIFO, fifth waits for the first pop.
        do_reset();
        ng = 0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k <= 10) drive(0, 32'h0030_0000 + 4 * ng);
            else host_req_i = '0;
            exp_g = (k < 4) || (k == 10);
            #1;
            check_eq("t3_gnt", {30'h0, host_gnt_o}, exp_g ? 32'h1 : 32'h0);
            check_eq("t3_dreq", {24'h0, device_req_o}, exp_g ? 32'h04 : 32'h0);
            exp_rv = (k >= 10) && ((k <= 13) || (k == 20));
            check_eq("t3_rvalid", {30'h0, host_rvalid_o}, exp_rv ? 32'h1 : 32'h0);
            if (exp_rv) begin
                exp_d = (k == 20) ? 32'h2000_0010 : (32'h2000_0000 | (4 * (k - 10)));
                check_eq("t3_rdata", host_rdata_o[31:0], exp_d);
            end
            if (exp_g) ng++;
        end

        // Slow RAM then GPIO: GPIO waits until the RAM tag has drained.
        do_reset();
        lat[0] = 3;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            host_req_i = '0;
            if (k == 0) drive(0, 32'h0010_0020);
            else if (k <= 4) drive(0, 32'h0020_0000);
            #1;
            check_eq("t4_gnt", {30'h0, host_gnt_o}, (k == 0 || k == 4) ? 32'h1 : 32'h0);
            check_eq("t4_dreq", {24'h0, device_req_o}, (k == 0) ? 32'h01 : ((k == 4) ? 32'h02 : 32'h0));
            check_eq("t4_rvalid", {30'h0, host_rvalid_o}, (k == 3 || k == 5) ? 32'h1 : 32'h0);
            if (k == 3) check_eq("t4_rdata_ram", host_rdata_o[31:0], 32'hDEADBEEF);
            if (k == 5) check_eq("t4_rdata_gpio", host_rdata_o[31:0], 32'h1000_0000);
        end
        lat[0] = 1;

        // Unmapped address: error slave answers next cycle, no device request.
        do_reset();
        @(negedge clk);
        drive(1, 32'h4000_0000);
        #1;
        check_eq("t5_gnt", {30'h0, host_gnt_o}, 32'h2);
        check_eq("t5_dreq", {24'h0, device_req_o}, 32'h0);
        @(negedge clk);
        host_req_i = '0;
        #1;
        check_eq("t5_rvalid", {30'h0, host_rvalid_o}, 32'h2);
        check_eq("t5_err", {30'h0, host_err_o}, 32'h2);
        check_eq("t5_rdata", host_rdata_o[63:32], 32'h0);

        // Reset with three UART reads in flight; late responses must be dropped.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 32'h0030_0000 + 4 * k);
            #1;
            check_eq("t6_gnt", {30'h0, host_gnt_o}, 32'h1);
        end
        do_reset();
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            #1;
            check_eq("t6_late_rvalid", {30'h0, host_rvalid_o}, 32'h0);
        end
        @(negedge clk);
        drive(0, 32'h0020_0004);
        drive(1, 32'h0020_0008);
        #1;
        check_eq("t6_rr_first", {30'h0, host_gnt_o}, 32'h1);
        @(negedge clk);
        #1;
        check_eq("t6_rr_second", {30'h0, host_gnt_o}, 32'h2);
        check_eq("t6_rdata", host_rdata_o[31:0], 32'h1000_0004);
        @(negedge clk);
        host_req_i = '0;
        #1;
        check_eq("t6_rvalid_last", {30'h0, host_rvalid_o}, 32'h2);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_xbar_pipelined.md
Name: bus_xbar_pipelined

Overview:
Parametrised successor to the single-outstanding system bus. It connects NrHosts hosts (core data port, debug SBA, future DMA) to NrDevices memory-mapped devices. Arbitration is round-robin, address decode is base/mask, and up to MaxOutstanding requests may be in flight. Unmapped addresses receive an internally generated error response. It sits between the Ibex data port / debug host and RAM, GPIO, PWM, UART, timer, SPI, sim-ctrl and debug memory.

Parameters:
NrHosts, 2, number of bus hosts (1..8)
NrDevices, 8, number of devices (1..16)
DataWidth, 32, data width in bits
AddressWidth, 32, address width in bits
MaxOutstanding, 4, depth of the response-tag FIFO (power of 2, >=1)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
host_req_i  in  1 x NrHosts  host request
host_gnt_o  out  1 x NrHosts  host grant
host_addr_i  in  AddressWidth x NrHosts  host address
host_we_i  in  1 x NrHosts  write enable
host_be_i  in  DataWidth/8 x NrHosts  byte enables
host_wdata_i  in  DataWidth x NrHosts  write data
host_rvalid_o  out  1 x NrHosts  response valid
host_rdata_o  out  DataWidth x NrHosts  read data
host_err_o  out  1 x NrHosts  response error
device_req_o  out  1 x NrDevices  device request
device_addr_o, device_we_o, device_be_o, device_wdata_o  out  as host x NrDevices  forwarded request fields
device_rvalid_i  in  1 x NrDevices  device response valid
device_rdata_i  in  DataWidth x NrDevices  device read data
device_err_i  in  1 x NrDevices  device error
cfg_device_addr_base  in  AddressWidth x NrDevices  device base address
cfg_device_addr_mask  in  AddressWidth x NrDevices  device address mask

Behaviour:
- Clock and reset: clk_i; rst_ni is asynchronous, active-low. All state clears on reset.
- Reset values: gnt, rvalid, err and device_req outputs are 0; rdata is 0. Tag FIFO is empty. Round-robin pointer = host 0.
- Decode: device d matches when (addr & mask[d]) == base[d]. If several devices match, the lowest index wins. No match means the request targets internal error slave E (index NrDevices).
- Arbitration (combinational):
  - Among requesting hosts, select the first at or after rr_ptr, wrapping.
  - After a grant, rr_ptr <= winner+1 mod NrHosts. Without a grant, rr_ptr holds.
- Grant conditions. The selected host is granted in the same cycle only if both hold:
  - (a) the FIFO is not full, or it is full and a response pops this cycle;
  - (b) the FIFO is empty, or the target equals the youngest outstanding target.
  - Rule (b) guarantees in-order responses across devices with differing latency.
  - When stalled, no grant and no device_req. The host must hold its request.
- Request forwarding: on grant, device_req_o[target]=1 in the same cycle, with addr/we/be/wdata copied from the winner. Devices accept unconditionally. Non-target device_req_o are 0, other fields don't-care. Target E issues no device_req.
- Tag FIFO: on grant, push {host index, target}. E entries complete exactly 1 cycle after grant.
- Response routing:
  - The head entry pops when device_rvalid_i[head.target] is 1 (or one cycle after the E grant).
  - That cycle: host_rvalid_o[head.host]=1, rdata/err from the device.
  - For E: rdata=0, err=1.
  - Response routing is combinational, with 0-cycle added latency.
- Simultaneous events: push and pop in the same cycle are allowed; count is unchanged, including when full.
- Protocol violations: device rvalid with an empty FIFO, or on a non-head device, is a protocol violation. It is ignored (no host response) and flagged by an assertion.
- Latency: single-cycle device (rvalid one cycle after req) gives back-to-back throughput of 1 req/cycle from one host to one device.
- Reset mid-operation: outstanding tags are discarded; late device responses after reset are ignored.
- Count width: $clog2(MaxOutstanding+1).
- Assertions: no FIFO overflow/underflow; at most one host_gnt_o per cycle; at most one device_req_o per cycle.

Test Plan:
- Host0 reads RAM (base 0x00100000, mask 0xFFFF0000), addr 0x00100010, device returns 0xDEADBEEF next cycle -> gnt same cycle; host_rvalid_o[0]=1 one cycle later, rdata=0xDEADBEEF, err=0.
- Both hosts request every cycle to GPIO -> grants alternate 0,1,0,1; none lost; each response routed to the correct host.
- Host0 issues 4 reads to UART, which delays rvalid 10 cycles, MaxOutstanding=4 -> 4 grants, then 5th request stalled until the first response; then granted in the pop cycle.
- Host0 reads RAM (device latency 3), then immediately requests GPIO -> GPIO request not granted until the FIFO is empty; responses arrive RAM then GPIO.
- Access to 0x40000000 (unmapped) -> granted; next cycle rvalid=1, err=1, rdata=0; no device_req asserted.
- Assert rst_ni low with 3 outstanding, release, then send a late device rvalid -> no host_rvalid; FIFO empty; rr_ptr=0.
